// File: rtl/register_uart_reporter.sv
// Watches a CPU register and streams every new value over an 8N1 UART as uppercase hex + CR LF.
// Values arriving mid-frame are held in a one-deep, latest-wins pending slot.
module register_uart_reporter #(
  parameter int unsigned REGISTER_WIDTH = 16,
  parameter int unsigned CLOCKS_PER_BIT = 434
) (
  input  logic                      clock,
  input  logic                      isReset,
  input  logic [REGISTER_WIDTH-1:0] register1Value,
  output logic                      txd,
  output logic                      busy,
  output logic [7:0]                droppedCount
);

  localparam int unsigned Digits = REGISTER_WIDTH / 4;
  localparam int unsigned CharW  = $clog2(Digits + 2);
  localparam int unsigned CntW   = $clog2(CLOCKS_PER_BIT);

  localparam logic [CharW-1:0] CrChar   = CharW'(Digits);
  localparam logic [CharW-1:0] LastChar = CharW'(Digits + 1);
  localparam logic [CntW-1:0]  LastCnt  = CntW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                    state_q, state_d;
  logic [REGISTER_WIDTH-1:0] last_q;
  logic [REGISTER_WIDTH-1:0] shadow_q, shadow_d;
  logic [REGISTER_WIDTH-1:0] pend_q, pend_d;
  logic                      pend_valid_q, pend_valid_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [2:0]                bit_q, bit_d;
  logic [CharW-1:0]          char_q, char_d;
  logic [7:0]                shift_q, shift_d;
  logic                      txd_q, txd_d;
  logic [7:0]                drop_q, drop_d;

  logic                      change;
  logic                      bit_end;
  logic                      frame_end;
  logic                      start_frame;
  logic [REGISTER_WIDTH-1:0] start_value;

  // ASCII code of character idx within the frame for the given value.
  function automatic logic [7:0] char_code(input logic [REGISTER_WIDTH-1:0] value,
                                           input logic [CharW-1:0]          idx);
    logic [3:0] nib;
    logic [7:0] code;
    nib = 4'(value >> (4 * (Digits - 1 - 32'(idx))));
    if (idx == CrChar) begin
      code = 8'h0D;
    end else if (idx == LastChar) begin
      code = 8'h0A;
    end else if (nib < 4'd10) begin
      code = 8'h30 + {4'h0, nib};
    end else begin
      code = 8'h37 + {4'h0, nib};
    end
    return code;
  endfunction

  assign change    = (register1Value != last_q);
  assign bit_end   = (cnt_q == LastCnt);
  assign frame_end = (state_q == StStop) && bit_end && (char_q == LastChar);

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    char_d       = char_q;
    shift_d      = shift_q;
    txd_d        = txd_q;
    drop_d       = drop_q;
    start_frame  = 1'b0;
    start_value  = register1Value;

    unique case (state_q)
      StIdle: begin
        start_frame = change;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (char_q != LastChar) begin
            state_d = StStart;
            char_d  = char_q + 1'b1;
            shift_d = char_code(shadow_q, char_q + 1'b1);
            txd_d   = 1'b0;
          end else if (change || pend_valid_q) begin
            // A change seen on the frame-end edge is newer than anything pending.
            start_frame = 1'b1;
            start_value = change ? register1Value : pend_q;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_frame) begin
      state_d  = StStart;
      shadow_d = start_value;
      char_d   = '0;
      shift_d  = char_code(start_value, '0);
      cnt_d    = '0;
      txd_d    = 1'b0;
    end

    if ((state_q != StIdle) && change) begin
      if (pend_valid_q && (drop_q != 8'hFF)) begin
        drop_d = drop_q + 1'b1;
      end
      if (!frame_end) begin
        pend_d       = register1Value;
        pend_valid_d = 1'b1;
      end
    end
    if (frame_end) begin
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (isReset) begin
      state_q      <= StIdle;
      last_q       <= '0;
      shadow_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      bit_q        <= '0;
      char_q       <= '0;
      shift_q      <= '0;
      txd_q        <= 1'b1;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= register1Value;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      char_q       <= char_d;
      shift_q      <= shift_d;
      txd_q        <= txd_d;
      drop_q       <= drop_d;
    end
  end

  assign txd          = txd_q;
  assign busy         = (state_q != StIdle);
  assign droppedCount = drop_q;

endmodule

// File: tb/tb_register_uart_reporter.sv
// Directed and randomized bench for register_uart_reporter: decodes the UART line and compares
// received text, busy run lengths and drop counts against a reference built from the value history.
module tb_register_uart_reporter;

  localparam int unsigned Cpb = 4;

  logic        clock = 1'b0;
  logic        isReset;
  logic [15:0] value;
  logic        txd;
  logic        busy;
  logic [7:0]  dropped;

  int          n_cmp = 0;
  int          n_bad = 0;
  byte unsigned rx_q[$];
  byte unsigned exp_q[$];
  int          busy_runs[$];
  string       hexdig = "0123456789ABCDEF";

  always #10 clock = ~clock;

  register_uart_reporter #(
    .REGISTER_WIDTH(16),
    .CLOCKS_PER_BIT(Cpb)
  ) dut (
    .clock         (clock),
    .isReset       (isReset),
    .register1Value(value),
    .txd           (txd),
    .busy          (busy),
    .droppedCount  (dropped)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected text for one value: four uppercase hex digits, MSB first, then CR LF.
  function automatic void push_frame(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(hexdig[4'(v >> (12 - 4 * i))]);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while ((busy !== 1'b0) && (n < limit)) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_idle_in_time"}, 32'(n < limit), 32'd1);
    @(negedge clock);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_rx_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; (i < exp_q.size()) && (i < rx_q.size()); i++) begin
      chk($sformatf("%s_rx%0d", tag, i), rx_q[i], exp_q[i]);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_busy(input string tag, input int len);
    chk({tag, "_busy_runs"}, busy_runs.size(), 1);
    if (busy_runs.size() > 0) chk({tag, "_busy_len"}, busy_runs[0], len);
    busy_runs.delete();
  endtask

  // UART receiver: start detected on the first low sample, bits sampled mid-period.
  initial begin
    int         cnt;
    int         idx;
    logic [7:0] rx_byte;
    cnt = -1;
    rx_byte = '0;
    forever begin
      @(negedge clock);
      if (isReset === 1'b1) begin
        cnt = -1;
      end else if (cnt < 0) begin
        if (txd === 1'b0) cnt = 0;
      end else begin
        cnt++;
        if ((cnt % int'(Cpb)) == int'(Cpb / 2)) begin
          idx = cnt / int'(Cpb);
          if (idx <= 8) begin
            rx_byte[idx-1] = txd;
          end else begin
            chk("stop_bit", txd, 1'b1);
            rx_q.push_back(rx_byte);
            cnt = -1;
          end
        end
      end
    end
  end

  initial begin
    int len;
    len = 0;
    forever begin
      @(negedge clock);
      if (busy === 1'b1) begin
        len++;
      end else if (len > 0) begin
        busy_runs.push_back(len);
        len = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cur;
    logic [15:0] v;
    int          k;
    int          exp_drop;

    isReset = 1'b1;
    value   = 16'h0000;
    repeat (3) @(negedge clock);
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", dropped, 8'd0);
    isReset = 1'b0;
    repeat (50) @(negedge clock);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_runs", busy_runs.size(), 0);
    check_rx("post_rst");

    // Single change: start bit on the detecting edge.
    value = 16'h1A2F;
    @(negedge clock);
    chk("s1_txd_fall", txd, 1'b0);
    chk("s1_busy_rise", busy, 1'b1);
    wait_idle("s1", 400);
    push_frame(16'h1A2F);
    check_rx("s1");
    check_busy("s1", 240);

    // Return to zero, then a long constant input.
    value = 16'h00FF;
    @(negedge clock);
    wait_idle("s2a", 400);
    check_busy("s2a", 240);
    value = 16'h0000;
    @(negedge clock);
    wait_idle("s2b", 400);
    check_busy("s2b", 240);
    repeat (1000) @(negedge clock);
    chk("quiet_runs", busy_runs.size(), 0);
    chk("quiet_busy", busy, 1'b0);
    push_frame(16'h00FF);
    push_frame(16'h0000);
    check_rx("s2");

    // Overlap: second arrival overwrites the first pending value.
    value = 16'h0001;
    repeat (21) @(negedge clock);
    value = 16'h0002;
    @(negedge clock);
    chk("ov_drop0", dropped, 8'd0);
    repeat (20) @(negedge clock);
    value = 16'h0003;
    @(negedge clock);
    chk("ov_drop1", dropped, 8'd1);
    wait_idle("ov", 1000);
    push_frame(16'h0001);
    push_frame(16'h0003);
    check_rx("ov");
    check_busy("ov", 480);

    // Change first sampled on the final stop-bit edge while 0002 is pending.
    value = 16'h0005;
    repeat (20) @(negedge clock);
    value = 16'h0002;
    repeat (220) @(negedge clock);
    value = 16'h0004;
    @(negedge clock);
    chk("edge_drop", dropped, 8'd2);
    chk("edge_busy", busy, 1'b1);
    chk("edge_txd_start", txd, 1'b0);
    wait_idle("edge", 1000);
    push_frame(16'h0005);
    push_frame(16'h0004);
    check_rx("edge");
    check_busy("edge", 480);

    // Random frames with 0..3 mid-frame arrivals; only the last one is sent.
    cur      = 16'h0004;
    exp_drop = 2;
    for (int it = 0; it < 6; it++) begin
      do v = 16'($urandom); while (v == cur);
      value = v;
      cur   = v;
      push_frame(v);
      @(negedge clock);
      k = int'($urandom_range(0, 3));
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(5, 40)) @(negedge clock);
        do v = 16'($urandom); while (v == cur);
        value = v;
        cur   = v;
      end
      if (k > 0) push_frame(cur);
      if (k > 1) exp_drop += k - 1;
      wait_idle("rnd", 1200);
      chk($sformatf("rnd%0d_drop", it), dropped, exp_drop);
      check_rx($sformatf("rnd%0d", it));
      check_busy($sformatf("rnd%0d", it), (k > 0) ? 480 : 240);
      repeat ($urandom_range(0, 5)) @(negedge clock);
    end

    // Change every cycle for long enough to saturate the drop counter.
    for (int i = 0; i < 600; i++) begin
      do v = 16'($urandom_range(0, 16'h0FFF)); while (v == cur);
      value = v;
      cur   = v;
      @(negedge clock);
    end
    chk("sat_drop", dropped, 8'd255);
    wait_idle("sat", 2000);
    chk("sat_drop_hold", dropped, 8'd255);
    rx_q.delete();
    exp_q.delete();
    busy_runs.delete();

    // Reset about 100 cycles into a frame, input held afterwards.
    value = 16'h1A2F;
    repeat (100) @(negedge clock);
    isReset = 1'b1;
    @(negedge clock);
    chk("mid_rst_txd", txd, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_drop", dropped, 8'd0);
    @(negedge clock);
    rx_q.delete();
    busy_runs.delete();
    isReset = 1'b0;
    @(negedge clock);
    chk("restart_txd", txd, 1'b0);
    chk("restart_busy", busy, 1'b1);
    wait_idle("restart", 400);
    push_frame(16'h1A2F);
    check_rx("restart");
    check_busy("restart", 240);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
